// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core result path.
package ooo_pkg;

  localparam int CDB_RD_W = 5;
  localparam int NO_TAG   = 0;

  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arb_if.sv
// Execution-unit result channels and the registered common data bus.
interface cdb_arb_if import ooo_pkg::*; #(
  parameter int N_CH   = 3,
  parameter int TAG_W  = 4,
  parameter int RD_W   = CDB_RD_W,
  parameter int DATA_W = 32
);

  logic [N_CH-1:0]        exu_valid;
  logic [N_CH-1:0]        exu_ready;
  logic [N_CH*TAG_W-1:0]  exu_tag;
  logic [N_CH*RD_W-1:0]   exu_rd;
  logic [N_CH*DATA_W-1:0] exu_data;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [RD_W-1:0]        cdb_rd;
  logic [DATA_W-1:0]      cdb_data;
  logic [N_CH-1:0]        cdb_grant;

  modport master (
    output exu_valid, exu_tag, exu_rd, exu_data,
    input  exu_ready, cdb_valid, cdb_tag, cdb_rd, cdb_data, cdb_grant
  );

  modport slave (
    input  exu_valid, exu_tag, exu_rd, exu_data,
    output exu_ready, cdb_valid, cdb_tag, cdb_rd, cdb_data, cdb_grant
  );

endinterface

// File: rtl/cdb_chq.sv
// Single-channel result FIFO: circular buffer with push/pop and flush.
module cdb_chq #(
  parameter int W     = 41,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wrap_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = wrap_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);

endmodule

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: per-channel queues, round-robin pick, registered broadcast.
module cdb_arb import ooo_pkg::*; #(
  parameter int N_CH    = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int RD_W    = CDB_RD_W,
  parameter int Q_DEPTH = 2
) (
  input logic      clk,
  input logic      rst,
  input logic      flush,
  cdb_arb_if.slave bus
);

  localparam int ENT_W = TAG_W + RD_W + DATA_W;
  localparam int RR_W  = $clog2(N_CH);

  logic [ENT_W-1:0] head [N_CH];
  logic [N_CH-1:0]  full, empty, pop;
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [N_CH-1:0]  cdb_grant_q, cdb_grant_d;
  logic [ENT_W-1:0] ent_q, ent_d;
  logic             found;
  int unsigned      idx, g_idx;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cdb_chq #(.W(ENT_W), .DEPTH(Q_DEPTH)) u_chq (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (bus.exu_valid[i]),
      .pop   (pop[i]),
      .din   ({bus.exu_tag[i*TAG_W +: TAG_W], bus.exu_rd[i*RD_W +: RD_W],
               bus.exu_data[i*DATA_W +: DATA_W]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    a_no_tag: assert property (@(posedge clk) disable iff (rst)
      !(bus.exu_valid[i] && (bus.exu_tag[i*TAG_W +: TAG_W] == TAG_W'(NO_TAG))));
  end

  assign bus.exu_ready = ~full;

  // Flush drops the pop as well: the queues ignore it while their flush is high.
  always_comb begin
    pop      = '0;
    found    = 1'b0;
    idx      = 0;
    g_idx    = 0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(rr_ptr_q) + k) % 32'(N_CH);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        g_idx = idx;
      end
    end
    if (found) begin
      pop[g_idx] = 1'b1;
      rr_ptr_d   = RR_W'(rr_next(g_idx, N_CH));
    end
    cdb_valid_d = found;
    cdb_grant_d = pop;
    ent_d       = found ? head[g_idx] : ent_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
      cdb_grant_d = '0;
      rr_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_grant_q <= '0;
      ent_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_grant_q <= cdb_grant_d;
      ent_q       <= ent_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_grant = cdb_grant_q;
  assign {bus.cdb_tag, bus.cdb_rd, bus.cdb_data} = ent_q;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(cdb_grant_q));

endmodule
